// File: rtl/mac_pkg.sv
// Shared definitions for the MAC datapath: operand/accumulator widths,
// control-strobe encodings and the signed operand/sum types.
package mac_pkg;

    localparam int DATA_W = 8;
    localparam int ACC_W  = 2 * DATA_W + 4;

    // sel1: start a new sum or add to the running one
    localparam logic SEL1_LOAD = 1'b1;
    localparam logic SEL1_ADD  = 1'b0;
    // sel2: accumulate this beat or hold the sum and emit it
    localparam logic SEL2_ACC  = 1'b1;
    localparam logic SEL2_EMIT = 1'b0;

    typedef logic signed [DATA_W-1:0] operand_t;
    typedef logic signed [ACC_W-1:0]  acc_t;

endpackage

// File: rtl/mac_res_fifo.sv
// First-word-fall-through result FIFO. Pointers carry one wrap bit above the
// index so full and empty come straight from the pointer compare.
module mac_res_fifo #(
    parameter int W     = 20,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty,
    output logic         accepted,
    output logic         dropped
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic [W-1:0] mem [DEPTH];
    logic         pop_en;

    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[AW] != rd_ptr[AW]) &&
                    (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_en = pop && !empty;

    // A push into a full FIFO still lands if the head leaves on the same edge.
    assign accepted = push && (!full || pop_en);
    assign dropped  = push && full && !pop_en;

    assign head = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (accepted) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop_en) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accepted) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/mac_dp.sv
// Multiply-accumulate datapath driven by the control unit's sel1/sel2 strobes,
// with finished sums queued in an output FIFO. MAC_DP_RELU_EN clamps emitted sums at 0.
module mac_dp #(
    parameter int DATA_W = mac_pkg::DATA_W,
    parameter int ACC_W  = 2 * DATA_W + 4,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sel1,
    input  logic                     sel2,
    input  logic signed [DATA_W-1:0] a_in,
    input  logic signed [DATA_W-1:0] b_in,
    output logic        [ACC_W-1:0]  res_data,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic                     overflow,
    output logic        [15:0]       res_count
);

    import mac_pkg::*;

    localparam int PROD_W = 2 * DATA_W;

    logic signed [PROD_W-1:0] prod_q;
    logic                     sel1_q;
    logic                     sel2_q;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  push_val;
    logic                     push_q;
    logic        [ACC_W-1:0]  push_data_q;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic                     fifo_accepted;
    logic                     fifo_dropped;

    assign prod_ext = {{(ACC_W-PROD_W){prod_q[PROD_W-1]}}, prod_q};

    always_comb begin
        push_val = acc;
`ifdef MAC_DP_RELU_EN
        if (acc[ACC_W-1]) begin
            push_val = '0;
        end
`endif
    end

    // Stage 1: product and strobes registered together so they stay aligned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod_q <= '0;
            sel1_q <= SEL1_LOAD;
            sel2_q <= SEL2_ACC;
        end else begin
            prod_q <= PROD_W'(a_in) * PROD_W'(b_in);
            sel1_q <= sel1;
            sel2_q <= sel2;
        end
    end

    // Stage 2: accumulate, or hold and register the sum as a FIFO push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc         <= '0;
            push_q      <= 1'b0;
            push_data_q <= '0;
        end else if (sel2_q == SEL2_ACC) begin
            push_q <= 1'b0;
            if (sel1_q == SEL1_LOAD) begin
                acc <= prod_ext;
            end else begin
                acc <= acc + prod_ext;
            end
        end else begin
            push_q      <= 1'b1;
            push_data_q <= push_val;
        end
    end

    // Output handshake: res_data is valid whenever res_valid=1 and holds until
    // a rising edge sees res_valid && res_ready; only then does the head leave.
    mac_res_fifo #(
        .W     (ACC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_q),
        .push_data (push_data_q),
        .pop       (res_ready),
        .head      (res_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .accepted  (fifo_accepted),
        .dropped   (fifo_dropped)
    );

    assign res_valid = !fifo_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            res_count <= '0;
        end else begin
            if (fifo_dropped) begin
                overflow <= 1'b1;
            end
            if (fifo_accepted) begin
                res_count <= res_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_mac_dp.sv
// Directed bench for mac_dp: per-cycle vector table plus hand-written
// sequences for overflow, full push/pop, async reset and accumulator wrap.
module tb_mac_dp;

  localparam int DATA_W = 8;
  localparam int ACC_W  = 20;
  localparam int NV     = 18;

  logic                     clk;
  logic                     rst;
  logic                     sel1;
  logic                     sel2;
  logic signed [DATA_W-1:0] a_in;
  logic signed [DATA_W-1:0] b_in;
  logic        [ACC_W-1:0]  res_data;
  logic                     res_valid;
  logic                     res_ready;
  logic                     overflow;
  logic        [15:0]       res_count;

  int total = 0;
  int bad   = 0;
  int exp_count;
  logic [ACC_W-1:0] exp_q[$];

  typedef struct {
    logic s1;
    logic s2;
    int   a;
    int   b;
    logic v;
    int   d;
    int   c;
  } vec_t;

  vec_t tbl[NV];

  mac_dp #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W),
    .DEPTH  (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sel1      (sel1),
    .sel2      (sel2),
    .a_in      (a_in),
    .b_in      (b_in),
    .res_data  (res_data),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .overflow  (overflow),
    .res_count (res_count)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic signed [63:0] rl(input logic signed [63:0] v);
`ifdef MAC_DP_RELU_EN
    return (v < 0) ? 64'sd0 : v;
`else
    return v;
`endif
  endfunction

  task automatic chk(input string name, input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // driver: apply one beat, let the edge sample it, settle 1 time unit
  task automatic step(input logic s1, input logic s2, input int a, input int b);
    sel1 = s1;
    sel2 = s2;
    a_in = DATA_W'(a);
    b_in = DATA_W'(b);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b1, 1'b1, 0, 0);
  endtask

  // scoreboard drain: every queued expectation must appear at the head in order
  task automatic drain(input string name);
    res_ready = 1'b1;
    while (exp_q.size() > 0) begin
      chk({name, "_valid"}, 64'(res_valid), 64'sd1);
      chk({name, "_data"}, $signed(res_data), $signed(exp_q.pop_front()));
      idle();
    end
    chk({name, "_empty"}, 64'(res_valid), 64'sd0);
    res_ready = 1'b0;
  endtask

  initial begin
    //             s1 s2   a     b   v  d       c
    tbl[0]  = '{1, 1,    3,    4, 0, 0,      0};
    tbl[1]  = '{0, 1,   -2,    5, 0, 0,      0};
    tbl[2]  = '{0, 1,    7,    1, 0, 0,      0};
    tbl[3]  = '{0, 0,    0,    0, 0, 0,      0};
    tbl[4]  = '{1, 1,    0,    0, 0, 0,      0};
    tbl[5]  = '{1, 1, -128, -128, 1, 9,      1};
    tbl[6]  = '{0, 1, -128, -128, 0, 0,      1};
    tbl[7]  = '{0, 1, -128, -128, 0, 0,      1};
    tbl[8]  = '{0, 1, -128, -128, 0, 0,      1};
    tbl[9]  = '{0, 0,    0,    0, 0, 0,      1};
    tbl[10] = '{1, 1,   -2,    3, 0, 0,      1};
    tbl[11] = '{0, 0,    0,    0, 1, 65536,  2};
    tbl[12] = '{1, 1,    5,    5, 0, 0,      2};
    tbl[13] = '{0, 1,   -3,   10, 1, -6,     3};
    tbl[14] = '{0, 0,    0,    0, 0, 0,      3};
    tbl[15] = '{1, 1,    0,    0, 0, 0,      3};
    tbl[16] = '{1, 1,    0,    0, 1, -5,     4};
    tbl[17] = '{1, 1,    0,    0, 0, 0,      4};

    rst = 1'b1;
    sel1 = 1'b1;
    sel2 = 1'b1;
    a_in = '0;
    b_in = '0;
    res_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 64'(res_valid), 64'sd0);
    chk("rst_data", $signed(res_data), 64'sd0);
    chk("rst_overflow", 64'(overflow), 64'sd0);
    chk("rst_count", 64'(res_count), 64'sd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // table: basic sum, extremes, negative sum, load-then-add to negative
    res_ready = 1'b1;
    for (int i = 0; i < NV; i++) begin
      step(tbl[i].s1, tbl[i].s2, tbl[i].a, tbl[i].b);
      chk($sformatf("vec%0d_valid", i), 64'(res_valid), 64'(tbl[i].v));
      if (tbl[i].v) begin
        chk($sformatf("vec%0d_data", i), $signed(res_data), rl(64'(tbl[i].d)));
      end
      chk($sformatf("vec%0d_count", i), 64'(res_count), 64'(tbl[i].c));
    end
    exp_count = 4;

    // accumulator wrap: 32 x 16384 = 2^19 wraps to -2^19 at ACC_W=20
    step(1'b1, 1'b1, -128, -128);
    repeat (31) step(1'b0, 1'b1, -128, -128);
    step(1'b0, 1'b0, 0, 0);
    idle();
    idle();
    exp_count++;
    chk("wrap_valid", 64'(res_valid), 64'sd1);
    chk("wrap_data", $signed(res_data), rl(-64'sd524288));
    chk("wrap_count", 64'(res_count), 64'(exp_count));
    idle();
    chk("wrap_popped", 64'(res_valid), 64'sd0);

    // overflow: five emits with no drain, fifth is dropped
    res_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      step(1'b1, 1'b1, k, 1);
      step(1'b0, 1'b0, 0, 0);
      if (k <= 4) exp_q.push_back(ACC_W'(k));
    end
    idle();
    idle();
    exp_count += 4;
    chk("ovf_flag", 64'(overflow), 64'sd1);
    chk("ovf_count", 64'(res_count), 64'(exp_count));
    drain("ovf_drain");
    chk("ovf_sticky", 64'(overflow), 64'sd1);

    // async reset mid-operation with two queued results and a partial sum
    step(1'b1, 1'b1, 7, 1);
    step(1'b0, 1'b0, 0, 0);
    step(1'b1, 1'b1, 8, 1);
    step(1'b0, 1'b0, 0, 0);
    idle();
    idle();
    chk("pre_rst_valid", 64'(res_valid), 64'sd1);
    step(1'b1, 1'b1, 5, 5);
    step(1'b0, 1'b1, 1, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", 64'(res_valid), 64'sd0);
    chk("arst_data", $signed(res_data), 64'sd0);
    chk("arst_overflow", 64'(overflow), 64'sd0);
    chk("arst_count", 64'(res_count), 64'sd0);
    sel1 = 1'b1;
    sel2 = 1'b1;
    a_in = '0;
    b_in = '0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    step(1'b0, 1'b0, 0, 0);
    idle();
    idle();
    chk("post_rst_acc", $signed(res_data), 64'sd0);
    chk("post_rst_count", 64'(res_count), 64'sd1);
    res_ready = 1'b1;
    idle();
    step(1'b1, 1'b1, 3, 4);
    step(1'b0, 1'b0, 0, 0);
    idle();
    idle();
    chk("post_rst_valid", 64'(res_valid), 64'sd1);
    chk("post_rst_sum", $signed(res_data), 64'sd12);
    chk("post_rst_count2", 64'(res_count), 64'sd2);
    idle();
    chk("post_rst_popped", 64'(res_valid), 64'sd0);
    exp_count = 2;

    // full FIFO with a push and a pop on the same edge
    res_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step(1'b1, 1'b1, 10 * k, 1);
      step(1'b0, 1'b0, 0, 0);
      exp_q.push_back(ACC_W'(10 * k));
    end
    step(1'b1, 1'b1, 50, 1);
    step(1'b0, 1'b0, 0, 0);
    idle();
    exp_count += 4;
    chk("full_head", $signed(res_data), 64'sd10);
    chk("full_count", 64'(res_count), 64'(exp_count));
    res_ready = 1'b1;
    idle();
    res_ready = 1'b0;
    exp_count++;
    void'(exp_q.pop_front());
    exp_q.push_back(ACC_W'(50));
    chk("pp_overflow", 64'(overflow), 64'sd0);
    chk("pp_count", 64'(res_count), 64'(exp_count));
    drain("pp_drain");
    chk("pp_overflow_end", 64'(overflow), 64'sd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
